// File: rtl/riscv_pkg.sv
// Shared encodings for the execute stage: ALU op codes, branch funct3,
// forwarding selects and the divider FSM state.
package riscv_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9,
    ALU_MUL  = 5'd10,
    ALU_DIV  = 5'd11,
    ALU_DIVU = 5'd12,
    ALU_REM  = 5'd13,
    ALU_REMU = 5'd14
  } alu_op_t;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

  function automatic logic is_div_op(input alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/mdu_div.sv
// Radix-2 restoring divider with start/busy/done handshake and signed fix-up.
module mdu_div
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DIV_LAT = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            signed_i,
  input  logic            rem_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CW = $clog2(DIV_LAT + 1);

  div_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
  logic            negq_q, negq_d, negr_q, negr_d, rsel_q, rsel_d, dz_q, dz_d;
  logic [XLEN-1:0] a_abs, b_abs, q_fix, r_fix;

  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] r,
                                                 input logic [XLEN-1:0] q,
                                                 input logic [XLEN-1:0] d);
    logic [XLEN:0] sh, diff;
    sh   = {r, q[XLEN-1]};
    diff = sh - {1'b0, d};
    if (!diff[XLEN]) return {diff[XLEN-1:0], q[XLEN-2:0], 1'b1};
    else             return {sh[XLEN-1:0],   q[XLEN-2:0], 1'b0};
  endfunction

  assign a_abs = (signed_i && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
  assign b_abs = (signed_i && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;

  // The first iteration runs on the acceptance edge, so BUSY lasts DIV_LAT-1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    rsel_d  = rsel_q;
    dz_d    = dz_q;
    case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          {rem_d, quo_d} = div_step('0, a_abs, b_abs);
          dvs_d   = b_abs;
          dvd_d   = dividend_i;
          negq_d  = signed_i & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
          negr_d  = signed_i & dividend_i[XLEN-1];
          rsel_d  = rem_i;
          dz_d    = (divisor_i == '0);
          cnt_d   = CW'(1);
          state_d = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (abort_i) begin
          cnt_d   = '0;
          state_d = DIV_IDLE;
        end else begin
          {rem_d, quo_d} = div_step(rem_q, quo_q, dvs_q);
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DIV_LAT - 1)) state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        cnt_d   = '0;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      rsel_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      rsel_q  <= rsel_d;
      dz_q    <= dz_d;
    end
  end

  assign q_fix    = dz_q ? '1    : (negq_q ? -quo_q : quo_q);
  assign r_fix    = dz_q ? dvd_q : (negr_q ? -rem_q : rem_q);
  assign result_o = rsel_q ? r_fix : q_fix;
  assign busy_o   = (state_q == DIV_BUSY);
  assign done_o   = (state_q == DIV_DONE);

endmodule

// File: rtl/exec_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution, iterative divide
// with stall, and the E->M pipeline register.
module exec_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DIV_LAT = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_e,
  input  logic [4:0]      alu_op_e,
  input  logic            alu_src_a_e,
  input  logic            alu_src_b_e,
  input  logic            branch_e,
  input  logic            jump_e,
  input  logic [2:0]      branch_type_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] imm_e,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] result_w,
  input  logic [XLEN-1:0] alu_result_m_in,
  input  logic [1:0]      forward_a_e,
  input  logic [1:0]      forward_b_e,
  input  logic [4:0]      rd_e,
  input  logic            reg_write_e,
  input  logic            mem_write_e,
  input  logic [2:0]      result_src_e,
  input  logic            flush_e,
  output logic            stall_e,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic            valid_m,
  output logic            reg_write_m,
  output logic            mem_write_m,
  output logic [2:0]      result_src_m,
  output logic [4:0]      rd_m,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [XLEN-1:0] pc_plus4_m
);

  localparam int unsigned SHW = $clog2(XLEN);

  alu_op_t         op;
  logic [XLEN-1:0] fwd_a, fwd_b, opa, opb, alu_out, div_result, alu_res;
  logic [SHW-1:0]  shamt;
  logic            taken, is_div, div_start, div_busy, div_done;

  logic            valid_q, reg_write_q, mem_write_q;
  logic [2:0]      result_src_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] alu_result_q, write_data_q, pc_plus4_q;

  assign op = alu_op_t'(alu_op_e);

  always_comb begin
    case (forward_a_e)
      FWD_W:   fwd_a = result_w;
      FWD_M:   fwd_a = alu_result_m_in;
      default: fwd_a = rd1_e;
    endcase
    case (forward_b_e)
      FWD_W:   fwd_b = result_w;
      FWD_M:   fwd_b = alu_result_m_in;
      default: fwd_b = rd2_e;
    endcase
  end

  assign opa   = alu_src_a_e ? pc_e  : fwd_a;
  assign opb   = alu_src_b_e ? imm_e : fwd_b;
  assign shamt = opb[SHW-1:0];

  always_comb begin
    alu_out = '0;
    case (op)
      ALU_ADD:  alu_out = opa + opb;
      ALU_SUB:  alu_out = opa - opb;
      ALU_AND:  alu_out = opa & opb;
      ALU_OR:   alu_out = opa | opb;
      ALU_XOR:  alu_out = opa ^ opb;
      ALU_SLL:  alu_out = opa << shamt;
      ALU_SRL:  alu_out = opa >> shamt;
      ALU_SRA:  alu_out = $signed(opa) >>> shamt;
      ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
      ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, opa < opb};
      ALU_MUL:  alu_out = opa * opb;
      default:  alu_out = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (branch_type_e)
      BR_BEQ:  taken = (fwd_a == fwd_b);
      BR_BNE:  taken = (fwd_a != fwd_b);
      BR_BLT:  taken = ($signed(fwd_a) <  $signed(fwd_b));
      BR_BGE:  taken = ($signed(fwd_a) >= $signed(fwd_b));
      BR_BLTU: taken = (fwd_a <  fwd_b);
      BR_BGEU: taken = (fwd_a >= fwd_b);
      default: taken = 1'b0;
    endcase
  end

  // A divide is accepted only from IDLE; reset and flush both veto acceptance.
  assign is_div    = is_div_op(op);
  assign div_start = valid_e & is_div & ~flush_e & ~reset & ~div_busy & ~div_done;
  assign stall_e   = div_start | div_busy;

  mdu_div #(
    .XLEN    (XLEN),
    .DIV_LAT (DIV_LAT)
  ) u_mdu_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_start),
    .abort_i    (flush_e),
    .signed_i   ((op == ALU_DIV) || (op == ALU_REM)),
    .rem_i      ((op == ALU_REM) || (op == ALU_REMU)),
    .dividend_i (opa),
    .divisor_i  (opb),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .result_o   (div_result)
  );

  assign alu_res     = (is_div && div_done) ? div_result : alu_out;
  assign pc_src_e    = valid_e & ~stall_e & (jump_e | (branch_e & taken));
  assign pc_target_e = pc_e + imm_e;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      rd_q         <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
    end else if (stall_e || flush_e) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q      <= valid_e;
      reg_write_q  <= reg_write_e;
      mem_write_q  <= mem_write_e;
      result_src_q <= result_src_e;
      rd_q         <= rd_e;
      alu_result_q <= alu_res;
      write_data_q <= fwd_b;
      pc_plus4_q   <= pc_e + XLEN'(4);
    end
  end

  assign valid_m      = valid_q;
  assign reg_write_m  = reg_write_q;
  assign mem_write_m  = mem_write_q;
  assign result_src_m = result_src_q;
  assign rd_m         = rd_q;
  assign alu_result_m = alu_result_q;
  assign write_data_m = write_data_q;
  assign pc_plus4_m   = pc_plus4_q;

endmodule
